rr_mux_4_1: RTL

Round-robin arbitrating 4:1 multiplexer with valid/ready handshakes and a registered output stage. Four independent producers present WIDTH-bit words. The block grants one of them per cycle using a rotating priority pointer and steers the granted word into a one-entry output register. It is the sequential front end of the combinational 4:1 data mux: it generates the 2-bit select, applies it, and holds the result until the consumer accepts it.

---
 rtl/rr_mux_4_1.sv | 85 ++++++++
 1 files changed

// File: rtl/rr_mux_4_1.sv
// Round-robin 4:1 arbitrating mux with valid/ready handshakes.
// Grants one producer per cycle into a one-entry output register.
module rr_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  logic [1:0]       ptr;
  logic [3:0]       rot;
  logic [1:0]       off;
  logic [1:0]       g;
  logic             any;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel;

  assign load_en = !out_valid || out_ready;
  assign any     = |in_valid;
  assign xfer    = load_en && any;

  // rot[k] is the request sitting k places after the pointer
  always_comb begin
    rot = '0;
    for (int k = 0; k < 4; k++) begin
      rot[k] = in_valid[2'(ptr + 2'(k))];
    end
  end

  always_comb begin
    off = 2'd0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign g = ptr + off;

  always_comb begin
    sel = '0;
    unique case (g)
      2'd0: sel = in_data0;
      2'd1: sel = in_data1;
      2'd2: sel = in_data2;
      2'd3: sel = in_data3;
      default: sel = '0;
    endcase
  end

  assign in_ready = (rst_n && xfer) ? (4'b0001 << g) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr       <= 2'd0;
    end else if (load_en) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= sel;
        out_src   <= g;
        ptr       <= g + 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
